// File: rtl/au_pkg.sv
// Shared definitions for the arithmetic unit and its writeback stage:
// opcode encodings, flag bit positions and the flags register width.
package au_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADDS = 3'd2;
    localparam logic [2:0] OP_SUBS = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_RTL  = 3'd6;
    localparam logic [2:0] OP_SAR  = 3'd7;

    localparam int FLAG_V  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_N  = 3;
    localparam int FLAG_SV = 4;

    localparam int FLAGS_W = 5;

    // Add/subtract family occupies the lower half of the opcode space; only
    // these produce a meaningful overflow.
    function automatic logic is_arith(input logic [2:0] opcode);
        return ~opcode[2];
    endfunction

endpackage

// File: rtl/au_wb_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with a synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module au_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/au_writeback.sv
// AU writeback stage: flags register {SV,N,Z,C,V} plus a result FIFO that
// drains to the register file. Define AU_WB_STICKY_OV_EN for the sticky SV bit.
module au_writeback
    import au_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RD_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_opcode,
    input  logic [RD_W-1:0]    in_rd,
    input  logic [15:0]        in_result,
    input  logic               in_carry,
    input  logic               in_overflow,
    input  logic               flush,
    input  logic               flags_load,
    input  logic [FLAGS_W-1:0] flags_din,
    output logic [FLAGS_W-1:0] flags_q,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RD_W-1:0]    wb_rd,
    output logic [15:0]        wb_data
);

    logic                  accept;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [RD_W+15:0]      head;
    logic [FLAG_N:FLAG_V]  nzcv;
    logic                  sv;
    logic [1:0]            unused_opcode_low;

    // in_ready depends only on the registered occupancy, never on wb_ready.
    assign in_ready = ~full;
    assign accept   = in_valid & in_ready & ~flush;
    assign wb_valid = ~empty;
    assign pop      = wb_valid & wb_ready;

    assign unused_opcode_low = in_opcode[1:0];

    au_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RD_W + 16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .flush (flush),
        .din   ({in_rd, in_result}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign {wb_rd, wb_data} = head;

    // A software load overrides any same-cycle result update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv <= '0;
        end else if (flags_load) begin
            nzcv <= flags_din[FLAG_N:FLAG_V];
        end else if (accept) begin
            nzcv[FLAG_N] <= in_result[15];
            nzcv[FLAG_Z] <= (in_result == 16'h0000);
            nzcv[FLAG_C] <= in_carry;
            if (is_arith(in_opcode)) begin
                nzcv[FLAG_V] <= in_overflow;
            end
        end
    end

`ifdef AU_WB_STICKY_OV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= 1'b0;
        end else if (flags_load) begin
            sv <= flags_din[FLAG_SV];
        end else if (accept && is_arith(in_opcode) && in_overflow) begin
            sv <= 1'b1;
        end
    end
`else
    logic unused_flags_din_sv;

    assign unused_flags_din_sv = flags_din[FLAG_SV];
    assign sv                  = 1'b0;
`endif

    assign flags_q = {sv, nzcv};

endmodule

// File: tb/tb_au_writeback.sv
// Scenario bench for au_writeback: a scoreboard queue tracks every accepted
// beat and checks it when the register file side pops it.
module tb_au_writeback;
    import au_pkg::*;

    localparam int DEPTH = 2;
    localparam int RD_W  = 3;

`ifdef AU_WB_STICKY_OV_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_opcode;
    logic [RD_W-1:0]    in_rd;
    logic [15:0]        in_result;
    logic               in_carry;
    logic               in_overflow;
    logic               flush;
    logic               flags_load;
    logic [FLAGS_W-1:0] flags_din;
    logic [FLAGS_W-1:0] flags_q;
    logic               wb_valid;
    logic               wb_ready;
    logic [RD_W-1:0]    wb_rd;
    logic [15:0]        wb_data;

    int checks = 0;
    int errors = 0;

    logic [RD_W+15:0] sb[$];
    logic [RD_W+15:0] mon_exp;
    bit               mon_full;

    au_writeback #(
        .DEPTH (DEPTH),
        .RD_W  (RD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rd       (in_rd),
        .in_result   (in_result),
        .in_carry    (in_carry),
        .in_overflow (in_overflow),
        .flush       (flush),
        .flags_load  (flags_load),
        .flags_din   (flags_din),
        .flags_q     (flags_q),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after a rising edge, so the falling edge sees exactly
    // what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (flush) begin
            sb.delete();
        end else begin
            mon_full = (sb.size() == DEPTH);
            if (wb_ready && sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checks++;
                if ({wb_rd, wb_data} !== mon_exp) begin
                    errors++;
                    $display("[TB] FAIL scoreboard got rd=%0d data=%h want rd=%0d data=%h",
                             wb_rd, wb_data, mon_exp[RD_W+15:16], mon_exp[15:0]);
                end
            end
            if (in_valid && !mon_full) begin
                sb.push_back({in_rd, in_result});
            end
        end
    end

    task automatic beat(input bit v, input logic [2:0] op, input logic [RD_W-1:0] rd,
                        input logic [15:0] res, input bit c, input bit ov);
        in_valid    = v;
        in_opcode   = op;
        in_rd       = rd;
        in_result   = res;
        in_carry    = c;
        in_overflow = ov;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        flush      = 1'b0;
        flags_load = 1'b0;
        flags_din  = '0;
        wb_ready   = 1'b0;
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        #2;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid got %b want 0", wb_valid); end
        checks++;
        if (wb_data !== 16'h0) begin errors++; $display("[TB] FAIL reset_wb_data got %h want 0000", wb_data); end
        checks++;
        if (wb_rd !== '0) begin errors++; $display("[TB] FAIL reset_wb_rd got %0d want 0", wb_rd); end
        checks++;
        if (flags_q !== 5'b0) begin errors++; $display("[TB] FAIL reset_flags got %b want 00000", flags_q); end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_zero();
        wb_ready = 1'b0;
        beat(1, OP_ADD, 1, 16'h0000, 1, 0);
        cyc(1);
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        checks++;
        if (flags_q !== 5'b0_0110) begin errors++; $display("[TB] FAIL add_zero_flags got %b want 00110", flags_q); end
        checks++;
        if (wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_zero_valid got %b want 1", wb_valid); end
        checks++;
        if (wb_data !== 16'h0000 || wb_rd !== 3'd1) begin
            errors++; $display("[TB] FAIL add_zero_head got rd=%0d data=%h want rd=1 data=0000", wb_rd, wb_data);
        end
        wb_ready = 1'b1;
        cyc(1);
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_zero_drained got %b want 0", wb_valid); end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        beat(1, OP_ADD, 2, 16'h1111, 0, 0);
        cyc(1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_one got %b want 1", in_ready); end
        beat(1, OP_ADD, 3, 16'h2222, 0, 0);
        cyc(1);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full got %b want 0", in_ready); end
        beat(1, OP_ADD, 4, 16'h3333, 0, 0);
        cyc(1);
        checks++;
        if (in_ready !== 1'b0 || wb_data !== 16'h1111) begin
            errors++; $display("[TB] FAIL bp_stalled got ready=%b data=%h want ready=0 data=1111", in_ready, wb_data);
        end
        wb_ready = 1'b1;
        cyc(1);
        checks++;
        if (in_ready !== 1'b1 || wb_data !== 16'h2222) begin
            errors++; $display("[TB] FAIL bp_first_pop got ready=%b data=%h want ready=1 data=2222", in_ready, wb_data);
        end
        cyc(1);
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        checks++;
        if (wb_data !== 16'h3333) begin errors++; $display("[TB] FAIL bp_third got %h want 3333", wb_data); end
        cyc(1);
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got %b want 0", wb_valid); end
        checks++;
        if (flags_q !== 5'b0) begin errors++; $display("[TB] FAIL bp_flags got %b want 00000", flags_q); end
    endtask

    task automatic test_shl_hold_v();
        logic [4:0] exp;
        wb_ready = 1'b1;
        beat(1, OP_ADD, 5, 16'h0001, 0, 1);
        cyc(1);
        exp = STICKY ? 5'b1_0001 : 5'b0_0001;
        checks++;
        if (flags_q !== exp) begin errors++; $display("[TB] FAIL shl_pre_v got %b want %b", flags_q, exp); end
        beat(1, OP_SHL, 6, 16'h8000, 1, 0);
        cyc(1);
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        exp = STICKY ? 5'b1_1011 : 5'b0_1011;
        checks++;
        if (flags_q !== exp) begin errors++; $display("[TB] FAIL shl_hold_v got %b want %b", flags_q, exp); end
        cyc(1);
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL shl_drained got %b want 0", wb_valid); end
    endtask

    task automatic test_load_priority();
        wb_ready   = 1'b1;
        flags_load = 1'b1;
        flags_din  = 5'b0_0001;
        beat(1, OP_SUB, 7, 16'h0000, 1, 1);
        cyc(1);
        flags_load = 1'b0;
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        checks++;
        if (flags_q !== 5'b0_0001) begin errors++; $display("[TB] FAIL load_priority got %b want 00001", flags_q); end
        cyc(1);
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_drained got %b want 0", wb_valid); end
    endtask

    task automatic test_flush();
        logic [4:0] exp;
        wb_ready = 1'b0;
        beat(1, OP_ADD, 1, 16'h00AA, 0, 0);
        cyc(1);
        beat(1, OP_ADD, 2, 16'h0055, 0, 0);
        cyc(1);
        checks++;
        if (wb_valid !== 1'b1 || flags_q !== 5'b0) begin
            errors++; $display("[TB] FAIL flush_pre got valid=%b flags=%b want valid=1 flags=00000", wb_valid, flags_q);
        end
        flush    = 1'b1;
        wb_ready = 1'b1;
        beat(1, OP_ADD, 3, 16'h8000, 1, 1);
        cyc(1);
        flush    = 1'b0;
        wb_ready = 1'b0;
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_empty got valid=%b ready=%b want valid=0 ready=1", wb_valid, in_ready);
        end
        checks++;
        if (flags_q !== 5'b0) begin errors++; $display("[TB] FAIL flush_flags got %b want 00000", flags_q); end
        beat(1, OP_ADD, 4, 16'h1234, 0, 0);
        cyc(1);
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        checks++;
        if (wb_data !== 16'h1234 || wb_rd !== 3'd4) begin
            errors++; $display("[TB] FAIL flush_refill got rd=%0d data=%h want rd=4 data=1234", wb_rd, wb_data);
        end
        flush      = 1'b1;
        flags_load = 1'b1;
        flags_din  = 5'b1_0100;
        cyc(1);
        flush      = 1'b0;
        flags_load = 1'b0;
        exp = STICKY ? 5'b1_0100 : 5'b0_0100;
        checks++;
        if (flags_q !== exp || wb_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_load got flags=%b valid=%b want flags=%b valid=0", flags_q, wb_valid, exp);
        end
        flags_load = 1'b1;
        flags_din  = 5'b0;
        cyc(1);
        flags_load = 1'b0;
    endtask

    task automatic test_sticky();
        logic [4:0] exp;
        wb_ready = 1'b1;
        beat(1, OP_ADDS, 1, 16'h0005, 0, 1);
        cyc(1);
        exp = STICKY ? 5'b1_0001 : 5'b0_0001;
        checks++;
        if (flags_q !== exp) begin errors++; $display("[TB] FAIL sticky_set got %b want %b", flags_q, exp); end
        beat(1, OP_ADD, 2, 16'h0005, 0, 0);
        cyc(1);
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        exp = STICKY ? 5'b1_0000 : 5'b0_0000;
        checks++;
        if (flags_q !== exp) begin errors++; $display("[TB] FAIL sticky_hold got %b want %b", flags_q, exp); end
        flags_load = 1'b1;
        flags_din  = 5'b0;
        cyc(1);
        flags_load = 1'b0;
        checks++;
        if (flags_q !== 5'b0) begin errors++; $display("[TB] FAIL sticky_clear got %b want 00000", flags_q); end
        cyc(1);
    endtask

    task automatic test_back_to_back();
        int guard;
        for (int i = 0; i < 80; i++) begin
            wb_ready = ($urandom_range(0, 3) != 0);
            beat(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), RD_W'($urandom_range(1, 7)),
                 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc(1);
        end
        beat(0, OP_ADD, 0, 16'h0, 0, 0);
        wb_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            cyc(1);
            guard++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("[TB] FAIL b2b_drain got %0d entries left want 0", sb.size());
        end
        checks++;
        if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty got %b want 0", wb_valid); end
    endtask

    initial begin
        test_reset();
        test_add_zero();
        test_backpressure();
        test_shl_hold_v();
        test_load_priority();
        test_flush();
        test_sticky();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
